shift_reg_loader: RTL and testbench

SHIFT_REG_LOADER -- requirements
Module: shift_reg_loader

---
 rtl/mem_pkg.sv | 21 ++
 rtl/loader_beat_packer.sv | 59 +++++
 rtl/shift_reg_loader.sv | 86 ++++++++
 tb/tb_shift_reg_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared parameters and element type for the shift-register memory blocks.
// Ports: none (package).
// DEPTH entries of signed bytes, filled BEAT_BYTES at a time over BEATS beats.
package mem_pkg;

  localparam int DEPTH      = 32;
  localparam int BEAT_BYTES = 8;
  localparam int BEATS      = DEPTH / BEAT_BYTES;

  localparam int LINE_W = DEPTH * 8;
  localparam int BEAT_W = BEAT_BYTES * 8;

  // beat counter must represent 0..BEATS inclusive (BEATS = "line parked")
  localparam int CNT_W = 3;

  // reload value for the drain counter: loads spaced exactly DEPTH cycles apart
  localparam logic [4:0] DRAIN_RELOAD = 5'(DEPTH - 1);

  typedef logic signed [7:0] elem_t;

endpackage

// File: rtl/loader_beat_packer.sv
// Assembles BEATS input beats into one DEPTH-element fill line.
// Ports: clock/reset; in_valid/in_ready/in_data beat input;
//        line_valid/line_take/line_data complete-line handoff to the top level.
// line_valid is also raised combinationally while the final beat is being
// accepted, so a free hold buffer can take the line with no extra cycle.
module loader_beat_packer
  import mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              line_valid,
  input  logic              line_take,
  output logic [LINE_W-1:0] line_data
);

  logic [LINE_W-1:0] fill;
  logic [LINE_W-1:0] fill_next;
  logic [CNT_W-1:0]  beat_cnt;
  logic              accept;

  // registered-state decode only; never depends on in_valid
  assign in_ready = (beat_cnt < CNT_W'(BEATS));
  assign accept   = in_valid && in_ready;

  always_comb begin
    fill_next = fill;
    for (int k = 0; k < BEATS; k++) begin
      if (accept && (beat_cnt == CNT_W'(k))) begin
        for (int j = 0; j < BEAT_BYTES; j++) begin
          fill_next[(k*BEAT_BYTES + j)*8 +: 8] = elem_t'(in_data[j*8 +: 8]);
        end
      end
    end
  end

  // the line presented includes the beat arriving this cycle
  assign line_data  = fill_next;
  assign line_valid = (beat_cnt == CNT_W'(BEATS)) ||
                      (accept && (beat_cnt == CNT_W'(BEATS - 1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill     <= '0;
      beat_cnt <= '0;
    end else begin
      fill <= fill_next;
      if (line_take) begin
        beat_cnt <= '0;
      end else if (accept) begin
        // last beat with no room in hold parks the line at beat_cnt == BEATS
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/shift_reg_loader.sv
// Feeds complete lines into a downstream shift register, one parallel load
// every DEPTH cycles at most, double-buffered (fill + hold).
// Ports: clock/reset; in_valid/in_ready/in_data beat input; write_data/
//        write_enable load output; starved flag; underflow_cnt statistics.
// Macro LOADER_STATS_EN enables the saturating underflow counter; without it
// underflow_cnt is tied to zero.
module shift_reg_loader
  import mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic [LINE_W-1:0] write_data,
  output logic              write_enable,
  output logic              starved,
  output logic [15:0]       underflow_cnt
);

  logic              line_valid;
  logic              line_take;
  logic [LINE_W-1:0] line_data;
  logic [LINE_W-1:0] hold_buf;
  logic              hold_full;
  logic              hold_free;
  logic [4:0]        drain_cnt;
  logic              primed;

  loader_beat_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .line_valid (line_valid),
    .line_take  (line_take),
    .line_data  (line_data)
  );

  assign write_enable = hold_full && (drain_cnt == 5'd0);
  // hold can accept a new line in the same cycle its current line is loaded
  assign hold_free    = !hold_full || write_enable;
  assign line_take    = line_valid && hold_free;
  assign write_data   = hold_buf;
  assign starved      = primed && (drain_cnt == 5'd0) && !hold_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_buf  <= '0;
      hold_full <= 1'b0;
      drain_cnt <= '0;
      primed    <= 1'b0;
    end else begin
      if (line_take) begin
        hold_buf  <= line_data;
        hold_full <= 1'b1;
      end else if (write_enable) begin
        hold_full <= 1'b0;
      end

      if (write_enable) begin
        drain_cnt <= DRAIN_RELOAD;
      end else if (drain_cnt != 5'd0) begin
        drain_cnt <= drain_cnt - 5'd1;
      end

      if (write_enable) begin
        primed <= 1'b1;
      end
    end
  end

`ifdef LOADER_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underflow_cnt <= '0;
    end else if (starved && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_shift_reg_loader.sv
module tb_shift_reg_loader;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic [255:0] write_data;
  logic         write_enable;
  logic         starved;
  logic [15:0]  underflow_cnt;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int last_beat_cyc = 0;
  int load_cyc[$];
  logic [255:0] load_dat[$];
  int starved_cnt = 0;
  int first_starved = -1;
  int nr_cnt = 0;
  int first_nr = -1;

  shift_reg_loader dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .starved       (starved),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  // observation at the falling edge, away from the active edge
  always @(negedge clock) begin
    if (write_enable) begin
      load_cyc.push_back(cyc);
      load_dat.push_back(write_data);
    end
    if (starved) begin
      if (starved_cnt == 0) first_starved = cyc;
      starved_cnt = starved_cnt + 1;
    end
    if (!in_ready) begin
      if (nr_cnt == 0) first_nr = cyc;
      nr_cnt = nr_cnt + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  function automatic logic [255:0] mk_line(input int base, input int step);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = 8'(base + step*i);
    return r;
  endfunction

  task automatic clear_mon();
    load_cyc.delete();
    load_dat.delete();
    starved_cnt = 0;
    first_starved = -1;
    nr_cnt = 0;
    first_nr = -1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    clear_mon();
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clock);
    @(negedge clock);
    last_beat_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_line(input logic [255:0] line);
    for (int k = 0; k < 4; k++) send_beat(line[k*64 +: 64]);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    tests++;
    if (write_enable !== 1'b0) begin fails++; $display("FAIL rst_write_enable got=%b exp=0", write_enable); end
    tests++;
    if (starved !== 1'b0) begin fails++; $display("FAIL rst_starved got=%b exp=0", starved); end
    tests++;
    if (write_data !== 256'd0) begin fails++; $display("FAIL rst_write_data got=%h exp=0", write_data); end
    tests++;
    if (underflow_cnt !== 16'd0) begin fails++; $display("FAIL rst_underflow got=%0d exp=0", underflow_cnt); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    clear_mon();
  endtask

  task automatic test_single_line();
    logic [255:0] ea;
    int c4;
    do_reset();
    ea = mk_line(0, 1);
    send_line(ea);
    c4 = last_beat_cyc;
    repeat (20) @(negedge clock);
    #2;
    tests++;
    if (load_cyc.size() !== 1) begin
      fails++; $display("FAIL single_load_count got=%0d exp=1", load_cyc.size());
    end else begin
      tests++;
      if (load_cyc[0] !== c4) begin fails++; $display("FAIL single_load_cycle got=%0d exp=%0d", load_cyc[0], c4); end
      tests++;
      if (load_dat[0] !== ea) begin fails++; $display("FAIL single_data got=%h exp=%h", load_dat[0], ea); end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ea, eb;
    do_reset();
    ea = mk_line(0, 1);
    eb = mk_line(-1, -1);
    send_line(ea);
    send_line(eb);
    repeat (40) @(negedge clock);
    #2;
    tests++;
    if (load_cyc.size() !== 2) begin
      fails++; $display("FAIL b2b_load_count got=%0d exp=2", load_cyc.size());
    end else begin
      tests++;
      if (load_cyc[1] - load_cyc[0] !== 32) begin fails++; $display("FAIL b2b_spacing got=%0d exp=32", load_cyc[1] - load_cyc[0]); end
      tests++;
      if (load_dat[1][7:0] !== 8'hFF) begin fails++; $display("FAIL b2b_elem0 got=%h exp=ff", load_dat[1][7:0]); end
      tests++;
      if (load_dat[0] !== ea) begin fails++; $display("FAIL b2b_data0 got=%h exp=%h", load_dat[0], ea); end
      tests++;
      if (load_dat[1] !== eb) begin fails++; $display("FAIL b2b_data1 got=%h exp=%h", load_dat[1], eb); end
    end
    tests++;
    if (nr_cnt !== 0) begin fails++; $display("FAIL b2b_in_ready_drops got=%0d exp=0", nr_cnt); end
  endtask

  task automatic test_stall();
    logic [255:0] e[3];
    int c12;
    do_reset();
    for (int n = 0; n < 3; n++) e[n] = mk_line(32*n, 1);
    for (int n = 0; n < 3; n++) send_line(e[n]);
    c12 = last_beat_cyc;
    repeat (70) @(negedge clock);
    #2;
    tests++;
    if (load_cyc.size() !== 3) begin
      fails++; $display("FAIL stall_load_count got=%0d exp=3", load_cyc.size());
    end else begin
      tests++;
      if (load_cyc[1] - load_cyc[0] !== 32) begin fails++; $display("FAIL stall_spacing01 got=%0d exp=32", load_cyc[1] - load_cyc[0]); end
      tests++;
      if (load_cyc[2] - load_cyc[1] !== 32) begin fails++; $display("FAIL stall_spacing12 got=%0d exp=32", load_cyc[2] - load_cyc[1]); end
      for (int n = 0; n < 3; n++) begin
        tests++;
        if (load_dat[n] !== e[n]) begin fails++; $display("FAIL stall_data%0d got=%h exp=%h", n, load_dat[n], e[n]); end
      end
    end
    // not ready from the cycle after beat 12 through the second load cycle
    tests++;
    if (nr_cnt !== 25) begin fails++; $display("FAIL stall_not_ready_cycles got=%0d exp=25", nr_cnt); end
    tests++;
    if (first_nr !== c12) begin fails++; $display("FAIL stall_first_not_ready got=%0d exp=%0d", first_nr, c12); end
  endtask

  task automatic test_starve();
    logic [255:0] ea, eb;
    int l1, g;
    do_reset();
    ea = mk_line(0, 1);
    eb = mk_line(5, 3);
    send_line(ea);
    l1 = last_beat_cyc;
    g = 0;
    while (cyc < l1 + 39 && g < 200) begin
      @(negedge clock);
      g++;
    end
    send_line(eb);
    #2;
    tests++;
    if (load_cyc.size() !== 2) begin
      fails++; $display("FAIL starve_load_count got=%0d exp=2", load_cyc.size());
    end else begin
      tests++;
      if (load_cyc[1] - load_cyc[0] !== 43) begin fails++; $display("FAIL starve_late_load got=%0d exp=43", load_cyc[1] - load_cyc[0]); end
      tests++;
      if (load_dat[1] !== eb) begin fails++; $display("FAIL starve_data got=%h exp=%h", load_dat[1], eb); end
    end
    tests++;
    if (starved_cnt !== 11) begin fails++; $display("FAIL starve_cycles got=%0d exp=11", starved_cnt); end
    tests++;
    if (first_starved !== l1 + 32) begin fails++; $display("FAIL starve_first got=%0d exp=%0d", first_starved, l1 + 32); end
    tests++;
    if (starved !== 1'b0) begin fails++; $display("FAIL starve_clear got=%b exp=0", starved); end
`ifdef LOADER_STATS_EN
    tests++;
    if (underflow_cnt !== 16'd11) begin fails++; $display("FAIL underflow_cnt got=%0d exp=11", underflow_cnt); end
`else
    tests++;
    if (underflow_cnt !== 16'd0) begin fails++; $display("FAIL underflow_cnt got=%0d exp=0", underflow_cnt); end
`endif
  endtask

  task automatic test_reset_mid_line();
    logic [255:0] ex, ey, ez, en;
    do_reset();
    ex = mk_line(1, 1);
    ey = mk_line(7, 2);
    ez = mk_line(9, 5);
    en = mk_line(100, 1);
    send_line(ex);
    send_line(ey);
    send_beat(ez[63:0]);
    send_beat(ez[127:64]);
    reset = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
    tests++;
    if (write_enable !== 1'b0) begin fails++; $display("FAIL mid_rst_write_enable got=%b exp=0", write_enable); end
    tests++;
    if (write_data !== 256'd0) begin fails++; $display("FAIL mid_rst_write_data got=%h exp=0", write_data); end
    tests++;
    if (starved !== 1'b0) begin fails++; $display("FAIL mid_rst_starved got=%b exp=0", starved); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    clear_mon();
    repeat (40) @(negedge clock);
    #2;
    tests++;
    if (load_cyc.size() !== 0) begin fails++; $display("FAIL mid_rst_stale_load got=%0d exp=0", load_cyc.size()); end
    send_line(en);
    #2;
    tests++;
    if (load_cyc.size() !== 1) begin
      fails++; $display("FAIL mid_rst_new_count got=%0d exp=1", load_cyc.size());
    end else begin
      tests++;
      if (load_cyc[0] !== last_beat_cyc) begin fails++; $display("FAIL mid_rst_no_wait got=%0d exp=%0d", load_cyc[0], last_beat_cyc); end
      tests++;
      if (load_dat[0] !== en) begin fails++; $display("FAIL mid_rst_data got=%h exp=%h", load_dat[0], en); end
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_back_to_back();
    test_stall();
    test_starve();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
